// File: rtl/hwag_ch_pkg.sv
// Shared types and defaults for HWAG angle-triggered output channels.
package hwag_ch_pkg;

  localparam int ANGLE_AW      = 24;
  localparam int ANGLE_TOP_DEF = 3839;

  typedef logic [ANGLE_AW-1:0] angle_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } ch_state_t;

endpackage

// File: rtl/hwag_angle_hit.sv
// Edge-qualified angle comparators: one event per arrival at a target angle,
// even if the angle is held for many cycles.
module hwag_angle_hit
  import hwag_ch_pkg::*;
#(
  parameter int AW  = 24,
  parameter int TOP = ANGLE_TOP_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] acnt2,
  input  logic [AW-1:0] tgt_set,
  input  logic [AW-1:0] tgt_clr,
  output logic          hit_set,
  output logic          hit_clr
);

  logic [AW-1:0] acnt2_q;
  logic          fresh;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acnt2_q <= '0;
    else      acnt2_q <= acnt2;
  end

  // Only a newly arrived, in-range angle can produce an event.
  assign fresh   = (acnt2 != acnt2_q) && (acnt2 <= AW'(TOP));
  assign hit_set = fresh && (acnt2 == tgt_set);
  assign hit_clr = fresh && (acnt2 == tgt_clr);

endmodule

// File: rtl/hwag_angle_channel.sv
// Angle-triggered output channel: set/clear by crank angle, with timeout,
// sync-loss abort and double-buffered configuration.
module hwag_angle_channel
  import hwag_ch_pkg::*;
#(
  parameter int AW  = 24,
  parameter int TOP = ANGLE_TOP_DEF,
  parameter int TW  = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hwag_start,
  input  logic [AW-1:0] acnt2,
  input  logic          acnt2_e_top,
  input  logic          cfg_we,
  input  logic          cfg_ena,
  input  logic [AW-1:0] cfg_set,
  input  logic [AW-1:0] cfg_clr,
  input  logic [TW-1:0] cfg_tmo,
  output logic          ch_out,
  output logic          ch_busy,
  output logic          cfg_pending,
  output logic          set_if,
  output logic          clr_if,
  output logic          tmo_if,
  output logic          abort_if
);

  logic          pend_ena, sh_ena;
  logic [AW-1:0] pend_set, pend_clr, sh_set, sh_clr;
  logic [TW-1:0] pend_tmo, sh_tmo;
  logic          top_q;
  logic          wrap, xfer;
  logic          hit_set, hit_clr;

  ch_state_t     state, state_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic          ch_out_nx, set_nx, clr_nx, tmo_nx, abort_nx;

  hwag_angle_hit #(.AW(AW), .TOP(TOP)) u_hit (
    .clk     (clk),
    .rst     (rst),
    .acnt2   (acnt2),
    .tgt_set (sh_set),
    .tgt_clr (sh_clr),
    .hit_set (hit_set),
    .hit_clr (hit_clr)
  );

  assign wrap = acnt2_e_top && !top_q;
  // The shadow never changes mid-pulse: ACTIVE defers to a later wrap.
  assign xfer = cfg_pending && ((state == IDLE) || ((state == ARMED) && wrap));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_ena    <= 1'b0;
      pend_set    <= '0;
      pend_clr    <= '0;
      pend_tmo    <= '0;
      sh_ena      <= 1'b0;
      sh_set      <= '0;
      sh_clr      <= '0;
      sh_tmo      <= '0;
      cfg_pending <= 1'b0;
      top_q       <= 1'b0;
    end else begin
      top_q <= acnt2_e_top;
      if (xfer) begin
        sh_ena      <= pend_ena;
        sh_set      <= pend_set;
        sh_clr      <= pend_clr;
        sh_tmo      <= pend_tmo;
        cfg_pending <= 1'b0;
      end
      // A coincident write wins: shadow takes the old pending, new stays queued.
      if (cfg_we) begin
        pend_ena    <= cfg_ena;
        pend_set    <= cfg_set;
        pend_clr    <= cfg_clr;
        pend_tmo    <= cfg_tmo;
        cfg_pending <= 1'b1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    state_nx  = state;
    tcnt_nx   = tcnt;
    ch_out_nx = 1'b0;
    set_nx    = 1'b0;
    clr_nx    = 1'b0;
    tmo_nx    = 1'b0;
    abort_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (hwag_start && sh_ena) state_nx = ARMED;
      end
      ARMED: begin
        if (!hwag_start || !sh_ena) begin
          state_nx = IDLE;
        end else if (hit_set && (sh_set != sh_clr)) begin
          state_nx  = ACTIVE;
          ch_out_nx = 1'b1;
          set_nx    = 1'b1;
          tcnt_nx   = '0;
        end
      end
      ACTIVE: begin
        ch_out_nx = 1'b1;
        if (tcnt != '1) tcnt_nx = tcnt + TW'(1);
        if (!hwag_start) begin
          state_nx  = IDLE;
          ch_out_nx = 1'b0;
          abort_nx  = 1'b1;
        end else if (hit_clr) begin
          state_nx  = ARMED;
          ch_out_nx = 1'b0;
          clr_nx    = 1'b1;
        end else if ((sh_tmo != '0) && (tcnt == sh_tmo - TW'(1))) begin
          state_nx  = ARMED;
          ch_out_nx = 1'b0;
          tmo_nx    = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tcnt     <= '0;
      ch_out   <= 1'b0;
      set_if   <= 1'b0;
      clr_if   <= 1'b0;
      tmo_if   <= 1'b0;
      abort_if <= 1'b0;
    end else begin
      state    <= state_nx;
      tcnt     <= tcnt_nx;
      ch_out   <= ch_out_nx;
      set_if   <= set_nx;
      clr_if   <= clr_nx;
      tmo_if   <= tmo_nx;
      abort_if <= abort_nx;
    end
  end

  assign ch_busy = (state == ACTIVE);

endmodule
